leaf_credit_arbiter: RTL and testbench



---
 rtl/leaf_credit_arbiter_pkg.sv | 24 ++
 rtl/leaf_credit_arbiter_rr_arbiter.sv | 42 ++++
 rtl/leaf_credit_arbiter.sv | 164 ++++++++++++++++
 tb/tb_leaf_credit_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_credit_arbiter_pkg.sv
// leaf_pkg: shared constants and helpers for the leaf credit-return arbiter
// and the round-robin arbiter it uses.
//   - valid_pos(): bit position of the packet valid bit (PACKET_BITS-1)
//   - ptr_w():     width of a round-robin pointer over NUM_REQ requesters
//   - SLOT_EMPTY / SLOT_FULL: output-slot state, encoded as the valid bit
package leaf_pkg;

  localparam int PACKET_BITS_DEFAULT = 97;
  localparam int VALID_POS_DEFAULT   = PACKET_BITS_DEFAULT - 1;

  // Output-slot state is exactly the valid bit of the registered packet.
  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_FULL  = 1'b1;

  function automatic int valid_pos(input int packet_bits);
    return packet_bits - 1;
  endfunction

  // At least one bit so a single-requester build still has a legal pointer.
  function automatic int ptr_w(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/leaf_credit_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
// Searches req starting at index ptr, wrapping modulo NUM_REQ, and grants the
// first set bit.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  PTR_W    index where the search starts (must be < NUM_REQ)
//   gnt     out NUM_REQ  one-hot grant (0 when nothing requested)
//   gnt_idx out PTR_W    index of the granted requester
//   gnt_vld out 1        some requester was granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  // Two passes: indices at/after ptr first, then the wrapped-around ones.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_vld && req[j] && (j >= int'(ptr))) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_vld && req[j] && (j < int'(ptr))) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/leaf_credit_arbiter.sv
// leaf_credit_arbiter: shares the leaf's single outgoing BFT packet slot among
// NUM_REQ credit-return requesters. Every freespace_update pulse is counted
// per requester; pending credits are granted round-robin and each accepted
// slot carries one registered packet built from the granted requester's
// template.
// Build option: define LEAF_ARB_COALESCE_EN to drain a requester's whole
// pending count in one packet (count carried in the low PAYLOAD_BITS).
// Ports:
//   clk                     in  1                    clock
//   reset                   in  1                    synchronous, active-high
//   freespace_update_vec    in  NUM_REQ              one-cycle credit pulses
//   packet_in_vec           in  NUM_REQ*PACKET_BITS  per-requester templates
//   dout_leaf_interface2bft out PACKET_BITS          registered packet, MSB = valid
//   resend                  in  1                    BFT refused; hold the slot
//   grant_onehot            out NUM_REQ              owner of the current packet
//   overflow_err            out 1                    sticky counter-overflow flag
module leaf_credit_arbiter
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS  = 97,
  parameter int PAYLOAD_BITS = 64,
  parameter int NUM_REQ      = 4,
  parameter int CNT_BITS     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             freespace_update_vec,
  input  logic [NUM_REQ*PACKET_BITS-1:0] packet_in_vec,
  output logic [PACKET_BITS-1:0]         dout_leaf_interface2bft,
  input  logic                           resend,
  output logic [NUM_REQ-1:0]             grant_onehot,
  output logic                           overflow_err
);

  localparam int                VLD     = valid_pos(PACKET_BITS);
  localparam int                PW      = ptr_w(NUM_REQ);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0]    cnt_q [NUM_REQ];
  logic [CNT_BITS-1:0]    cnt_d [NUM_REQ];
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PACKET_BITS-1:0] dout_q, dout_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   ovf_q, ovf_d;

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [PW-1:0]          arb_idx;
  logic                   arb_vld;
  logic                   adv;
  logic [NUM_REQ-1:0]     inc_v;
  logic [NUM_REQ-1:0]     dec_v;
  logic [PACKET_BITS-1:0] sel_pkt;
`ifdef LEAF_ARB_COALESCE_EN
  logic [CNT_BITS-1:0]    sel_cnt;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = |cnt_q[i];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // The slot may take a new packet when empty, or when the BFT accepted the
  // one currently held.
  assign adv   = (dout_q[VLD] == SLOT_EMPTY) || !resend;
  assign inc_v = freespace_update_vec;
  assign dec_v = arb_gnt & {NUM_REQ{adv}};

  // Template is read in the grant cycle, not captured at pulse time.
  always_comb begin
    sel_pkt = '0;
`ifdef LEAF_ARB_COALESCE_EN
    sel_cnt = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_pkt = packet_in_vec[i*PACKET_BITS +: PACKET_BITS];
`ifdef LEAF_ARB_COALESCE_EN
        sel_cnt = cnt_q[i];
`endif
      end
    end
  end

  // Per-requester pending-credit counters; a coincident pulse and grant
  // cancel out so no credit is lost.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
`ifdef LEAF_ARB_COALESCE_EN
      if (dec_v[i]) begin
        cnt_d[i] = inc_v[i] ? CNT_BITS'(1) : '0;
      end else if (inc_v[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
`else
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
`endif
    end
  end

  // Output slot: load granted packet, or go EMPTY when nothing is pending.
  always_comb begin
    dout_d  = dout_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (adv) begin
      if (arb_vld) begin
        dout_d      = sel_pkt;
        dout_d[VLD] = SLOT_FULL;
`ifdef LEAF_ARB_COALESCE_EN
        dout_d[PAYLOAD_BITS-1:0] = PAYLOAD_BITS'(sel_cnt);
`else
        dout_d[PAYLOAD_BITS-1:0] = sel_pkt[PAYLOAD_BITS-1:0];
`endif
        grant_d = arb_gnt;
        ptr_d   = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end else begin
        dout_d  = '0;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      grant_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      grant_q <= grant_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign grant_onehot            = grant_q;
  assign overflow_err            = ovf_q;

endmodule

// File: tb/tb_leaf_credit_arbiter.sv
// Testbench for leaf_credit_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// credit-count model of the arbiter kept in the bench.
module tb_leaf_credit_arbiter;

  localparam int N    = 4;
  localparam int PB   = 97;
  localparam int PL   = 64;
  localparam int CB   = 4;
  localparam int MAXC = (1 << CB) - 1;

  logic              clk;
  logic              reset_r;
  logic [N-1:0]      fsu;
  logic [N*PB-1:0]   pkt_vec;
  logic              resend_r;
  logic [PB-1:0]     dout;
  logic [N-1:0]      gnt;
  logic              ovf;

  leaf_credit_arbiter #(
    .PACKET_BITS  (PB),
    .PAYLOAD_BITS (PL),
    .NUM_REQ      (N),
    .CNT_BITS     (CB)
  ) dut (
    .clk                     (clk),
    .reset                   (reset_r),
    .freespace_update_vec    (fsu),
    .packet_in_vec           (pkt_vec),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend_r),
    .grant_onehot            (gnt),
    .overflow_err            (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: pending credits per requester, next search start, outputs.
  int          m_cnt [N];
  int          m_ptr;
  logic [PB-1:0] m_dout;
  logic [N-1:0]  m_gnt;
  logic          m_ovf;
  logic          chk_en;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the arbiter, from its rules, using the inputs driven.
  task automatic model_step();
    int   g;
    int   c;
    logic adv;
    if (reset_r) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ptr  = 0;
      m_dout = '0;
      m_gnt  = '0;
      m_ovf  = 1'b0;
      return;
    end
    adv = !m_dout[PB-1] || !resend_r;
    g = -1;
    if (adv) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_cnt[(m_ptr + k) % N] != 0) g = (m_ptr + k) % N;
      end
    end
    c = (g >= 0) ? m_cnt[g] : 0;
    for (int i = 0; i < N; i++) begin
`ifdef LEAF_ARB_COALESCE_EN
      if (i == g) m_cnt[i] = fsu[i] ? 1 : 0;
      else if (fsu[i]) begin
        if (m_cnt[i] == MAXC) m_ovf = 1'b1;
        else                  m_cnt[i] = m_cnt[i] + 1;
      end
`else
      if (fsu[i] && i != g) begin
        if (m_cnt[i] == MAXC) m_ovf = 1'b1;
        else                  m_cnt[i] = m_cnt[i] + 1;
      end else if (!fsu[i] && i == g) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
`endif
    end
    if (adv) begin
      if (g >= 0) begin
        m_dout = pkt_vec[g*PB +: PB];
        m_dout[PB-1] = 1'b1;
`ifdef LEAF_ARB_COALESCE_EN
        m_dout[PL-1:0] = PL'(c);
`endif
        m_gnt = N'(1) << g;
        m_ptr = (g + 1) % N;
      end else begin
        m_dout = '0;
        m_gnt  = '0;
      end
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", 128'(dout), 128'(m_dout));
      chk("grant_onehot", 128'(gnt), 128'(m_gnt));
      chk("overflow_err", 128'(ovf), 128'(m_ovf));
    end
  end

  task automatic step(input logic [N-1:0] p, input logic rs, input logic rst);
    fsu      = p;
    resend_r = rs;
    reset_r  = rst;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [PB-1:0] tmpl(input int i);
    logic [31:0] tag;
    tag = 32'hA0 + 32'(i);
    return {1'b0, tag, 64'd1};
  endfunction

  task automatic set_templates();
    for (int i = 0; i < N; i++) pkt_vec[i*PB +: PB] = tmpl(i);
  endtask

  task automatic rand_templates();
    for (int b = 0; b < N*PB; b++) pkt_vec[b] = 1'($urandom_range(0, 1));
  endtask

  int            nvalid;
  logic [PB-1:0] held;
  logic [PB-1:0] t2;

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_dout = '0; m_gnt = '0; m_ovf = 1'b0;
    chk_en = 1'b1;
    set_templates();
    fsu = '0; resend_r = 1'b0; reset_r = 1'b1;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("reset_dout", 128'(dout), 128'd0);
    chk("reset_grant", 128'(gnt), 128'd0);
    chk("reset_ovf", 128'(ovf), 128'd0);

    // Single pulse on requester 2
    step(4'b0100, 1'b0, 1'b0);
    chk("single_not_combinational", 128'(dout[PB-1]), 128'd0);
    step(4'b0000, 1'b0, 1'b0);
    t2 = tmpl(2);
    chk("single_packet", 128'(dout), 128'({1'b1, t2[PB-2:0]}));
    chk("single_grant", 128'(gnt), 128'h4);
    step(4'b0000, 1'b0, 1'b0);
    chk("single_empty_after", 128'(dout), 128'd0);

    // All requesters at once -> 0,1,2,3
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk("all_order", 128'(gnt), 128'(1 << k));
    end
    step(4'b0000, 1'b0, 1'b0);
    chk("all_drained", 128'(dout[PB-1]), 128'd0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("all_ptr_wrapped", 128'(gnt), 128'h1);

    // Backpressure on requester 1
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    held = dout;
    chk("bp_first_grant", 128'(gnt), 128'h2);
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b1, 1'b0);
      chk("bp_hold_dout", 128'(dout), 128'(held));
      chk("bp_hold_grant", 128'(gnt), 128'h2);
    end
    step(4'b0000, 1'b0, 1'b0);
    chk("bp_advance_valid", 128'(dout[PB-1]), 128'd1);
    chk("bp_advance_grant", 128'(gnt), 128'h2);
    step(4'b0000, 1'b0, 1'b0);
    chk("bp_single_decrement", 128'(dout[PB-1]), 128'd0);

    // Simultaneous inc/dec on requester 0
    step(4'b0000, 1'b0, 1'b1);
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      step(4'b0001, 1'b0, 1'b0);
      nvalid += int'(dout[PB-1]);
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      nvalid += int'(dout[PB-1]);
    end
    chk("incdec_packets", 128'(nvalid), 128'd10);
    chk("incdec_no_ovf", 128'(ovf), 128'd0);

    // Saturation on requester 3 under backpressure
    step(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) step(4'b1000, 1'b1, 1'b0);
    chk("sat_no_ovf_at_15", 128'(ovf), 128'd0);
    step(4'b1000, 1'b1, 1'b0);
    chk("sat_ovf", 128'(ovf), 128'd1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("sat_ovf_sticky", 128'(ovf), 128'd1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    chk("midhold_reset_dout", 128'(dout), 128'd0);
    chk("midhold_reset_ovf", 128'(ovf), 128'd0);
    step(4'b0000, 1'b1, 1'b0);
    chk("midhold_counters_cleared", 128'(dout), 128'd0);

`ifdef LEAF_ARB_COALESCE_EN
    // Coalesced drain of five credits
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("coal_grant", 128'(gnt), 128'h2);
    chk("coal_payload", 128'(dout[PL-1:0]), 128'd5);
    step(4'b0000, 1'b0, 1'b0);
    chk("coal_counter_zero", 128'(dout[PB-1]), 128'd0);
`endif

    // Randomized traffic: light and heavy backpressure, occasional resets
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] p;
      logic         rs;
      logic         rst;
      if ($urandom_range(0, 15) == 0) rand_templates();
      p   = N'($urandom) & N'($urandom);
      if (k >= 1000 && k < 1600) begin
        p  = N'($urandom) | N'($urandom);
        rs = ($urandom_range(0, 9) != 0);
      end else begin
        rs = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      step(p, rs, rst);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
